// File: rtl/alu_share_arbiter.sv
// Round-robin share of one registered ALU between two requesters with a tagged response (stats ports under ALU_SHARE_STATS_EN).
// Latency: accept in cycle T, rsp_valid in T+ALU_LAT+2; a new grant may coincide with rsp_valid.
// Backpressure: reqN_ready pulses only when no op is in flight; responses cannot be stalled.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             req0_valid,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic             alu_AddorSub,
  output logic             alu_ALUS0,
  output logic             alu_ALUS1,
  output logic             alu_L_R,
  input  logic [WIDTH-1:0] alu_Z,
  input  logic             alu_O,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_o,
  output logic             busy
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]      stat_ops0,
  output logic [15:0]      stat_ops1,
  output logic [15:0]      stat_ovf
`endif
);

  localparam int CW = 3;

  // op bit order matches the request op field: [0]=ALUS0 [1]=ALUS1 [2]=AddorSub [3]=L_R
  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_cmd_t;

  typedef struct packed {
    logic             id;
    logic             o;
    logic [WIDTH-1:0] z;
  } rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  alu_cmd_t      cmd_q, cmd_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  rsp_t          rsp_q, rsp_d;

  alu_cmd_t      cmd0, cmd1;
  logic          grant_vld;
  logic          grant_id;

  always_comb begin
    cmd0.op = req0_op;
    cmd0.a  = req0_a;
    cmd0.b  = req0_b;
    cmd1.op = req1_op;
    cmd1.a  = req1_a;
    cmd1.b  = req1_b;
  end

  // DONE accepts like IDLE so back-to-back ops lose no cycle
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q != ST_WAIT) begin
      case ({req1_valid, req0_valid})
        2'b01: begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end
        2'b10: begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end
        2'b11: begin
          grant_vld = 1'b1;
          grant_id  = ~last_q;
        end
        default: begin
          grant_vld = 1'b0;
          grant_id  = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = grant_vld & ~grant_id & ~Rst;
  assign req1_ready = grant_vld &  grant_id & ~Rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    owner_d = owner_q;
    last_d  = last_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_d.id = owner_q;
          rsp_d.o  = alu_O;
          rsp_d.z  = alu_Z;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (grant_vld) begin
          cmd_d   = grant_id ? cmd1 : cmd0;
          owner_d = grant_id;
          last_d  = grant_id;
          cnt_d   = CW'(ALU_LAT);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rsp_q   <= rsp_d;
    end
  end

  assign alu_A        = cmd_q.a;
  assign alu_B        = cmd_q.b;
  assign alu_ALUS0    = cmd_q.op[0];
  assign alu_ALUS1    = cmd_q.op[1];
  assign alu_AddorSub = cmd_q.op[2];
  assign alu_L_R      = cmd_q.op[3];

  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_id    = rsp_q.id;
  assign rsp_z     = rsp_q.z;
  assign rsp_o     = rsp_q.o;
  assign busy      = (state_q == ST_WAIT);

`ifdef ALU_SHARE_STATS_EN
  logic [15:0] ops0_q, ops0_d;
  logic [15:0] ops1_q, ops1_d;
  logic [15:0] ovf_q, ovf_d;

  // op counters wrap; overflow counter saturates
  always_comb begin
    ops0_d = ops0_q;
    ops1_d = ops1_q;
    ovf_d  = ovf_q;
    if (req0_ready) ops0_d = ops0_q + 16'd1;
    if (req1_ready) ops1_d = ops1_q + 16'd1;
    if (rsp_valid && rsp_o && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ops0_q <= '0;
      ops1_q <= '0;
      ovf_q  <= '0;
    end else begin
      ops0_q <= ops0_d;
      ops1_q <= ops1_d;
      ovf_q  <= ovf_d;
    end
  end

  assign stat_ops0 = ops0_q;
  assign stat_ops1 = ops1_q;
  assign stat_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed ops against a behavioural ALU, responses checked by a scoreboard monitor.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

  localparam int W   = 32;
  localparam int LAT = 1;
  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0100;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         req0_valid, req1_valid;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic [W-1:0] alu_A, alu_B, alu_Z;
  logic         alu_AddorSub, alu_ALUS0, alu_ALUS1, alu_L_R, alu_O;
  logic         rsp_valid, rsp_id, rsp_o, busy;
  logic [W-1:0] rsp_z;
`ifdef ALU_SHARE_STATS_EN
  logic [15:0]  stat_ops0, stat_ops1, stat_ovf;
`endif

  alu_share_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .alu_A(alu_A), .alu_B(alu_B), .alu_AddorSub(alu_AddorSub), .alu_ALUS0(alu_ALUS0),
    .alu_ALUS1(alu_ALUS1), .alu_L_R(alu_L_R), .alu_Z(alu_Z), .alu_O(alu_O),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_o(rsp_o), .busy(busy)
`ifdef ALU_SHARE_STATS_EN
    , .stat_ops0(stat_ops0), .stat_ops1(stat_ops1), .stat_ovf(stat_ovf)
`endif
  );

  always #5 Clk = ~Clk;

  // behavioural registered ALU: Z reflects the inputs LAT cycles earlier
  function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s0, input logic s1, input logic sub, input logic lr);
    logic [W-1:0] r;
    logic         o;
    o = 1'b0;
    case ({s1, s0})
      2'b00: begin
        r = sub ? a - b : a + b;
        o = sub ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1]))
                : ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
      end
      2'b01:   r = a & b;
      2'b10:   r = a | b;
      default: r = lr ? (a << b[4:0]) : (a >> b[4:0]);
    endcase
    return {o, r};
  endfunction

  logic [W:0] pipe [LAT];
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= alu_f(alu_A, alu_B, alu_ALUS0, alu_ALUS1, alu_AddorSub, alu_L_R);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign alu_Z = pipe[LAT-1][W-1:0];
  assign alu_O = pipe[LAT-1][W];

  typedef struct packed { logic id; logic o; logic [W-1:0] z; } exp_t;
  typedef struct packed { logic [3:0] op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] z; logic o; } vec_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   spacing_en = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=event", nm);
  endtask

  function automatic vec_t mkv(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] z, input logic o);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.z = z; v.o = o;
    return v;
  endfunction

  task automatic drive(input int r, input vec_t v);
    if (r == 0) begin req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b; end
    else        begin req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b; end
  endtask

  task automatic idle_req(input int r);
    if (r == 0) begin req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; end
    else        begin req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; end
  endtask

  task automatic push_exp(input int r, input vec_t v);
    exp_t e;
    e.id = r[0]; e.o = v.o; e.z = v.z;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input int r, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if ((r == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      tmo("drain");
      exp_q.delete();
    end
  endtask

  task automatic run_single(input int r, input vec_t v);
    bit ok;
    push_exp(r, v);
    drive(r, v);
    wait_ready(r, 20, ok);
    if (!ok) tmo("single_ready");
    @(posedge Clk); #1;
    idle_req(r);
    wait_drain(20);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    @(negedge Clk);
    @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  // scoreboard monitor plus requester-protocol watch
  exp_t e_mon;
  bit   prev_rsp = 1'b0;
  bit   pend0 = 1'b0, pend1 = 1'b0;
  int   last_rsp = -1;
  always @(negedge Clk) begin
    if (!spacing_en) last_rsp = -1;
    if (Rst) begin
      acc_q.delete();
      prev_rsp = 1'b0;
      pend0 = 1'b0;
      pend1 = 1'b0;
    end else begin
      if (pend0 && !req0_valid) tmo("proto_req0_dropped");
      if (pend1 && !req1_valid) tmo("proto_req1_dropped");
      pend0 = req0_valid && !req0_ready;
      pend1 = req1_valid && !req1_ready;
      if (req0_ready || req1_ready) acc_q.push_back(cyc);
      if (rsp_valid) begin
        chk("rsp_single_pulse", 64'(prev_rsp), 64'(0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: actual=rsp_valid z=%0h required=no response", rsp_z);
        end else begin
          e_mon = exp_q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e_mon.id));
          chk("rsp_z", 64'(rsp_z), 64'(e_mon.z));
          chk("rsp_o", 64'(rsp_o), 64'(e_mon.o));
        end
        if (acc_q.size() == 0) tmo("rsp_no_accept");
        else chk("rsp_latency", 64'(cyc - acc_q.pop_front()), 64'(LAT + 2));
        if (spacing_en && last_rsp >= 0) chk("rsp_spacing", 64'(cyc - last_rsp), 64'(LAT + 2));
        last_rsp = cyc;
      end
      prev_rsp = rsp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v2, v3, v4a, v4b, vm;
    vec_t r0v [3];
    vec_t r1v [3];
    vec_t s0a, s0b, s0c, s1a, s1b;
    bit   ok, g0, g1;
    int   i0, i1, seen;

    v2  = mkv(ADD, 32'd110, 32'd500, 32'd610, 1'b0);
    v3  = mkv(SUB, 32'd800, 32'd100, 32'd700, 1'b0);
    v4a = mkv(SUB, 32'd600, 32'd200, 32'd400, 1'b0);
    v4b = mkv(ADD, 32'd110, 32'd500, 32'd610, 1'b0);
    vm  = mkv(ADD, 32'd5,   32'd6,   32'd11,  1'b0);
    r0v[0] = mkv(ADD, 32'd10,         32'd20, 32'd30,         1'b0);
    r0v[1] = mkv(SUB, 32'd1000,       32'd1,  32'd999,        1'b0);
    r0v[2] = mkv(ADD, 32'hFFFF_FFFF,  32'd1,  32'd0,          1'b0);
    r1v[0] = mkv(SUB, 32'd7,          32'd7,  32'd0,          1'b0);
    r1v[1] = mkv(SUB, 32'h8000_0000,  32'd1,  32'h7FFF_FFFF,  1'b1);
    r1v[2] = mkv(ADD, 32'd123,        32'd456, 32'd579,       1'b0);
    s0a = mkv(ADD, 32'd1,           32'd2, 32'd3,          1'b0);
    s0b = mkv(ADD, 32'h7FFF_FFFF,   32'd1, 32'h8000_0000,  1'b1);
    s0c = mkv(SUB, 32'd9,           32'd4, 32'd5,          1'b0);
    s1a = mkv(ADD, 32'd3,           32'd3, 32'd6,          1'b0);
    s1b = mkv(SUB, 32'd100,         32'd1, 32'd99,         1'b0);

    idle_req(0);
    idle_req(1);

    // reset values
    #5 Rst = 1'b1;
    #15;
    chk("rst_req0_ready", 64'(req0_ready), 64'(0));
    chk("rst_req1_ready", 64'(req1_ready), 64'(0));
    chk("rst_alu_A", 64'(alu_A), 64'(0));
    chk("rst_alu_B", 64'(alu_B), 64'(0));
    chk("rst_alu_ctrl", 64'({alu_L_R, alu_AddorSub, alu_ALUS1, alu_ALUS0}), 64'(0));
    chk("rst_rsp", 64'({rsp_valid, rsp_id, rsp_o}), 64'(0));
    chk("rst_rsp_z", 64'(rsp_z), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
`ifdef ALU_SHARE_STATS_EN
    chk("rst_stats", 64'({stat_ops0, stat_ops1, stat_ovf}), 64'(0));
`endif
    @(posedge Clk);
    Rst = 1'b0;
    @(posedge Clk); #1;

    // op accepted, then reset in the following cycle: no response, ALU inputs cleared
    drive(0, vm);
    wait_ready(0, 10, ok);
    if (!ok) tmo("midop_ready");
    @(posedge Clk); #1;
    idle_req(0);
    chk("midop_busy", 64'(busy), 64'(1));
    #2 Rst = 1'b1;
    #1;
    chk("midop_alu_A", 64'(alu_A), 64'(0));
    chk("midop_alu_B", 64'(alu_B), 64'(0));
    chk("midop_busy_clr", 64'(busy), 64'(0));
    @(posedge Clk); #1;
    Rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (rsp_valid) seen++;
    end
    chk("midop_no_rsp", 64'(seen), 64'(0));
    @(posedge Clk); #1;

    // requester 0 alone
    run_single(0, v2);

    // requester 1 alone; ALU inputs held through WAIT
    @(posedge Clk); #1;
    push_exp(1, v3);
    drive(1, v3);
    wait_ready(1, 10, ok);
    if (!ok) tmo("t3_ready");
    chk("t3_req0_ready", 64'(req0_ready), 64'(0));
    @(posedge Clk); #1;
    idle_req(1);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge Clk);
      chk("t3_addsub_held", 64'(alu_AddorSub), 64'(1));
      chk("t3_alu_A_held", 64'(alu_A), 64'(800));
      chk("t3_alu_B_held", 64'(alu_B), 64'(100));
      chk("t3_busy", 64'(busy), 64'(1));
    end
    @(negedge Clk);
    chk("t3_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("t3_busy_done", 64'(busy), 64'(0));
    wait_drain(10);
    @(negedge Clk);
    chk("t3_rsp_z_hold", 64'(rsp_z), 64'(700));
    chk("t3_rsp_id_hold", 64'(rsp_id), 64'(1));
    chk("t3_alu_A_idle_hold", 64'(alu_A), 64'(800));

    // simultaneous requests straight after reset: requester 0 first
    @(posedge Clk); #1;
    do_reset();
    push_exp(0, v4a);
    push_exp(1, v4b);
    drive(0, v4a);
    drive(1, v4b);
    wait_ready(0, 10, ok);
    if (!ok) tmo("t4_ready0");
    chk("t4_req1_not_ready", 64'(req1_ready), 64'(0));
    @(posedge Clk); #1;
    idle_req(0);
    wait_ready(1, 10, ok);
    if (!ok) tmo("t4_ready1");
    chk("t4_ready1_with_rsp", 64'(rsp_valid), 64'(1));
    @(posedge Clk); #1;
    idle_req(1);
    wait_drain(20);

    // both held valid for six ops: strict alternation, fixed spacing
    @(posedge Clk); #1;
    for (int k = 0; k < 3; k++) begin
      push_exp(0, r0v[k]);
      push_exp(1, r1v[k]);
    end
    spacing_en = 1'b1;
    drive(0, r0v[0]);
    drive(1, r1v[0]);
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 60 && (i0 < 3 || i1 < 3); c++) begin
      @(negedge Clk);
      g0 = req0_ready;
      g1 = req1_ready;
      if (g0 || g1) chk("t5_one_grant", 64'(g0 && g1), 64'(0));
      @(posedge Clk); #1;
      if (g0) begin
        i0++;
        if (i0 < 3) drive(0, r0v[i0]); else idle_req(0);
      end
      if (g1) begin
        i1++;
        if (i1 < 3) drive(1, r1v[i1]); else idle_req(1);
      end
    end
    if (i0 < 3 || i1 < 3) begin
      tmo("t5_grants");
      idle_req(0);
      idle_req(1);
    end
    wait_drain(20);
    spacing_en = 1'b0;

    // stats sequence: 3 ops on requester 0 (one overflowing), 2 on requester 1
    @(posedge Clk); #1;
    do_reset();
    run_single(0, s0a);
    @(posedge Clk); #1;
    run_single(1, s1a);
    @(posedge Clk); #1;
    run_single(0, s0b);
    @(posedge Clk); #1;
    run_single(1, s1b);
    @(posedge Clk); #1;
    run_single(0, s0c);
    @(negedge Clk);
`ifdef ALU_SHARE_STATS_EN
    chk("stat_ops0", 64'(stat_ops0), 64'(3));
    chk("stat_ops1", 64'(stat_ops1), 64'(2));
    chk("stat_ovf", 64'(stat_ovf), 64'(1));
`endif
    chk("final_idle_busy", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one Sync_ALUcode instance between two requesters: arbitrates, issues one op at a time, waits out ALU latency, returns tagged result.
- Sits between the two requester blocks and the registered ALU.
- Drives the ALU's A, B, AddorSub, ALUS0, ALUS1 and L_R inputs.
- Captures the ALU's Z and O outputs.

Parameters:
- WIDTH, 32: operand/result width; must match the ALU.
- ALU_LAT, 1: ALU input-register to Z-valid latency in cycles; legal range 1-7.

Ports:
- Clk  input  1  single clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an op pending.
- req0_op  input  4  op code: [0]=ALUS0, [1]=ALUS1, [2]=AddorSub, [3]=L_R.
- req0_a  input  WIDTH  operand A.
- req0_b  input  WIDTH  operand B.
- req0_ready  output  1  one-cycle accept pulse.
- req1_valid, req1_op, req1_a, req1_b, req1_ready: same as requester 0, for requester 1.
- alu_A  output  WIDTH  to ALU A.
- alu_B  output  WIDTH  to ALU B.
- alu_AddorSub  output  1  to ALU.
- alu_ALUS0  output  1  to ALU.
- alu_ALUS1  output  1  to ALU.
- alu_L_R  output  1  to ALU.
- alu_Z  input  WIDTH  ALU result.
- alu_O  input  1  ALU overflow flag.
- rsp_valid  output  1  one-cycle result pulse.
- rsp_id  output  1  requester that owns the result.
- rsp_z  output  WIDTH  captured result.
- rsp_o  output  1  captured overflow.
- busy  output  1  high from accept until the cycle before rsp_valid.

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=1, so requester 0 wins the first tie.
- Reset is asynchronous. Asserting Rst mid-operation drops the in-flight op: no rsp_valid, ALU inputs return to 0.
- Handshake:
  - Requester holds valid, op, a and b stable until it sees ready.
  - reqN_ready is high for exactly one cycle, only when reqN_valid=1 and state=IDLE.
  - No response backpressure; rsp_* is valid only while rsp_valid=1.
  - rsp_z, rsp_o and rsp_id hold their values until the next response.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if any valid, grant one requester in cycle T: assert readyN and register operands/op onto alu_* at the end of T. Go to WAIT with cnt=ALU_LAT, busy=1.
  - WAIT: alu_* held stable. cnt decrements each cycle. Z is valid in cycle T+ALU_LAT+1; capture it at the end of that cycle into rsp_z/rsp_o, with rsp_id=grant, then go to DONE.
  - DONE: rsp_valid=1 and busy=0 in cycle T+ALU_LAT+2. DONE behaves as IDLE in the same cycle, so a new grant may occur concurrently with rsp_valid.
  - Throughput: one op per ALU_LAT+2 cycles.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester other than last_grant (round-robin).
  - last_grant updates on every grant.
- Valid dropping before grant is a protocol violation; behaviour is undefined, and the bench asserts it never happens.
- Width: operands pass unmodified; no arithmetic in this block. alu_* outputs hold the last issued op while IDLE.
- The ALU's own reset is driven by the same Rst.

Optional Feature:
- Macro: ALU_SHARE_STATS_EN.
- With the macro defined:
  - Adds outputs stat_ops0 and stat_ops1, 16 bits each: count of accepted ops per requester, wrapping at 0xFFFF to 0.
  - Adds output stat_ovf, 16 bits: count of responses with rsp_o=1, saturating at 0xFFFF.
  - All counters reset to 0 on Rst.
  - Counters increment in the cycle after the ready/rsp_valid that triggers them.
- Without the macro: none of these ports or registers exist; all other behaviour is identical.

Test Plan:
1. Rst high at 5 ns, low at 25 ns, with a mid-op reset. Before the reset, all outputs are 0, and an op accepted then reset 1 cycle later produces no rsp_valid.
2. Req0 only: a=110, b=500, op=0000, ALU_LAT=1. Accept pulse in cycle T; rsp_valid in T+3 with rsp_z=610, rsp_id=0, rsp_o=0.
3. Req1 only: a=800, b=100, op=0100. rsp_z=700, rsp_id=1. alu_AddorSub=1 is held throughout WAIT.
4. Both valid in the same cycle after reset: req0 {600,200,sub} and req1 {110,500,add}. Req0 is granted first (rsp 400, id 0), then req1 (rsp 610, id 1). req1_ready is asserted in the same cycle as the first rsp_valid.
5. Both held valid continuously for 6 ops. Grants alternate 0,1,0,1,0,1, and rsp_valid pulses are exactly ALU_LAT+2 cycles apart.
6. With ALU_SHARE_STATS_EN defined: 3 ops on req0, 2 on req1, and one 0x7FFFFFFF+1 add that sets O. Result: stat_ops0=3, stat_ops1=2, stat_ovf=1.
